ads1115_target: RTL and testbench



---
 rtl/ads1115_target.sv | 165 ++++++++++++++++
 tb/tb_ads1115_target.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1115_target.sv
// ads1115_target: I2C target emulating the ADS1115 pointer, config and conversion registers
module ads1115_target #(
  parameter logic [6:0] ADDRESS = 7'b1001001,
  parameter int CONV_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] adc0,
  input  logic [15:0] adc1,
  input  logic [15:0] adc2,
  input  logic [15:0] adc3,
  output logic [15:0] config_reg,
  output logic        config_wr,
  output logic        busy
);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_OUT, WR_BYTE, RD_BYTE, ACK_IN} state_t;
  state_t state, state_next;
  logic [2:0] scl_s, sda_s;
  logic rise, fall, start, stop, sda_in, match, load;
  logic [3:0] bit_cnt;
  logic [7:0] shift, msb_hold, tx_lsb, rx_byte, ld_byte;
  logic [6:0] tx_shift;
  logic sda_low, rw, first, byte_idx, rd_lsb;
  logic [1:0] pointer, sel;
  logic [15:0] conversion, cur_word, sample;
  logic [CW-1:0] cnt;
  assign sda = (sda_low && rst_n) ? 1'b0 : 1'bz;
  assign sda_in = sda_s[1];
  assign rise = scl_s[1] & ~scl_s[2];
  assign fall = ~scl_s[1] & scl_s[2];
  assign start = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
  assign stop = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
  assign rx_byte = {shift[6:0], sda_in};
  assign match = shift[7:1] == ADDRESS;
  assign cur_word = pointer == 2'd0 ? conversion :
                    pointer == 2'd1 ? {~busy, config_reg[14:0]} :
                    pointer == 2'd2 ? 16'h8000 : 16'h7fff;
  assign ld_byte = rd_lsb ? tx_lsb : cur_word[15:8];
  assign load = fall && (state == ACK_OUT ? rw : state == ACK_IN && bit_cnt == 4'd9);
  assign sel = config_reg[14] ? config_reg[13:12] : 2'd0;
  assign sample = sel == 2'd0 ? adc0 : sel == 2'd1 ? adc1 : sel == 2'd2 ? adc2 : adc3;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], scl};
      sda_s <= {sda_s[1:0], sda};
    end
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_next;
  always_comb begin
    state_next = state;
    if (start) state_next = ADDR;
    else if (stop) state_next = IDLE;
    else
      case (state)
        ADDR:    if (fall && bit_cnt == 4'd8) state_next = match ? ACK_OUT : IDLE;
        ACK_OUT: if (fall) state_next = rw ? RD_BYTE : WR_BYTE;
        WR_BYTE: if (fall && bit_cnt == 4'd8) state_next = ACK_OUT;
        RD_BYTE: if (fall && bit_cnt == 4'd8) state_next = ACK_IN;
        ACK_IN:  state_next = rise && sda_in ? IDLE : load ? RD_BYTE : ACK_IN;
        default: state_next = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift <= '0;
      msb_hold <= '0;
      tx_shift <= '0;
      tx_lsb <= '0;
      sda_low <= 1'b0;
      rw <= 1'b0;
      first <= 1'b0;
      byte_idx <= 1'b0;
      rd_lsb <= 1'b0;
      pointer <= '0;
      config_reg <= 16'h0583;
      config_wr <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      conversion <= '0;
    end else begin
      config_wr <= 1'b0;
      if (busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          conversion <= sample;
        end
      end
      if (start) begin
        bit_cnt <= '0;
        sda_low <= 1'b0;
      end else if (stop) sda_low <= 1'b0;
      else
        case (state)
          ADDR: begin
            if (rise && bit_cnt < 4'd8) begin
              shift <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (fall && bit_cnt == 4'd8) begin
              sda_low <= match;
              rw <= shift[0];
              first <= 1'b1;
              rd_lsb <= 1'b0;
            end
          end
          WR_BYTE: begin
            if (rise && bit_cnt < 4'd8) begin
              shift <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (first) begin
                  pointer <= rx_byte[1:0];
                  first <= 1'b0;
                  byte_idx <= 1'b0;
                end else if (!byte_idx) begin
                  msb_hold <= rx_byte;
                  byte_idx <= 1'b1;
                end else begin
                  byte_idx <= 1'b0;
                  if (pointer == 2'd1) begin
                    config_reg <= {1'b0, msb_hold[6:0], rx_byte};
                    config_wr <= 1'b1;
                    if (msb_hold[7] && !busy) begin
                      busy <= 1'b1;
                      cnt <= CW'(CONV_CYCLES);
                    end
                  end
                end
              end
            end
            if (fall && bit_cnt == 4'd8) sda_low <= 1'b1;
          end
          RD_BYTE: begin
            if (rise && bit_cnt < 4'd8) bit_cnt <= bit_cnt + 4'd1;
            if (fall) begin
              sda_low <= bit_cnt == 4'd8 ? 1'b0 : ~tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end
          end
          ACK_OUT, ACK_IN: begin
            if (rise) bit_cnt <= 4'd9;
            if (fall) begin
              bit_cnt <= '0;
              sda_low <= 1'b0;
            end
          end
          default: sda_low <= 1'b0;
        endcase
      if (load) begin
        tx_shift <= ld_byte[6:0];
        sda_low <= ~ld_byte[7];
        rd_lsb <= ~rd_lsb;
        if (!rd_lsb) tx_lsb <= cur_word[7:0];
      end
    end
  end
endmodule

// File: tb/tb_ads1115_target.sv
// tb_ads1115_target: bit-banged I2C controller with scoreboard and vector table against ads1115_target
module tb_ads1115_target;
  localparam int CONV = 1500;
  localparam int Q = 5;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  logic [15:0] adc0 = 16'hA001, adc1 = 16'h1234, adc2 = 16'hC0DE, adc3 = 16'h7E57;
  logic [15:0] config_reg;
  logic config_wr, busy;
  wire sda;
  int checks = 0, errors = 0, wr_cnt = 0, run = 0, last_len = 0, drove = 0;
  typedef struct {
    string tag;
    logic [7:0] val;
  } exp_t;
  typedef struct {
    logic [7:0] msb;
    logic [7:0] lsb;
    logic [15:0] cfg;
    logic conv;
    logic [15:0] result;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[5];
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  ads1115_target #(.ADDRESS(7'b1001001), .CONV_CYCLES(CONV)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3),
    .config_reg(config_reg), .config_wr(config_wr), .busy(busy)
  );
  always @(posedge clk) begin
    if (config_wr) wr_cnt <= wr_cnt + 1;
    if (busy) run <= run + 1;
    else if (run != 0) begin
      last_len <= run;
      run <= 0;
    end
  end
  always @(negedge clk) if (!m_low && sda === 1'b0) drove <= drove + 1;
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask
  task automatic bit_io(input logic b, output logic r);
    m_low = !b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    r = sda;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask
  task automatic i2c_start;
    m_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask
  task automatic i2c_stop;
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b0;
    wait_clk(Q);
  endtask
  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic r;
    exp_t e;
    e.tag = tag;
    e.val = {7'd0, exp_ack};
    sb.push_back(e);
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    e = sb.pop_front();
    chk(e.tag, 32'(!r), 32'(e.val));
  endtask
  task automatic rd_byte(input logic [7:0] exp, input logic nack, input string tag);
    logic r;
    logic [7:0] d;
    exp_t e;
    e.tag = tag;
    e.val = exp;
    sb.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(nack, r);
    e = sb.pop_front();
    chk(e.tag, 32'(d), 32'(e.val));
  endtask
  task automatic write_cfg(input logic [7:0] p, input logic [7:0] m, input logic [7:0] l, input string tag);
    i2c_start;
    wr_byte(8'h92, 1'b1, {tag, "_addr_ack"});
    wr_byte(p, 1'b1, {tag, "_ptr_ack"});
    wr_byte(m, 1'b1, {tag, "_msb_ack"});
    wr_byte(l, 1'b1, {tag, "_lsb_ack"});
    i2c_stop;
  endtask
  task automatic read2(input logic [7:0] p, input logic [15:0] exp, input string tag);
    i2c_start;
    wr_byte(8'h92, 1'b1, {tag, "_waddr_ack"});
    wr_byte(p, 1'b1, {tag, "_ptr_ack"});
    i2c_start;
    wr_byte(8'h93, 1'b1, {tag, "_raddr_ack"});
    rd_byte(exp[15:8], 1'b0, {tag, "_msb"});
    rd_byte(exp[7:0], 1'b1, {tag, "_lsb"});
    wait_clk(2);
    chk({tag, "_release_after_nack"}, 32'(sda), 32'd1);
    i2c_stop;
  endtask
  task automatic wait_busy_low;
    int n;
    n = 0;
    while (busy && n < CONV + 200) begin
      wait_clk(1);
      n++;
    end
    chk("busy_timeout", 32'(busy), 32'd0);
    wait_clk(2);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int w0, d0;
    logic r;
    vecs[0] = '{8'hC5, 8'h83, 16'h4583, 1'b1, 16'hA001};
    vecs[1] = '{8'hE5, 8'h83, 16'h6583, 1'b1, 16'hC0DE};
    vecs[2] = '{8'hF5, 8'h83, 16'h7583, 1'b1, 16'h7E57};
    vecs[3] = '{8'h85, 8'h83, 16'h0583, 1'b1, 16'hA001};
    vecs[4] = '{8'h65, 8'h0F, 16'h650F, 1'b0, 16'hA001};
    wait_clk(4);
    chk("reset_config", 32'(config_reg), 32'h0583);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_config_wr", 32'(config_wr), 32'd0);
    chk("reset_sda", 32'(sda), 32'd1);
    rst_n = 1'b1;
    wait_clk(5);
    d0 = drove;
    i2c_start;
    wr_byte(8'h90, 1'b0, "mismatch_ack");
    i2c_stop;
    chk("mismatch_drive", 32'(drove - d0), 32'd0);
    chk("mismatch_config", 32'(config_reg), 32'h0583);
    w0 = wr_cnt;
    write_cfg(8'h01, 8'hD3, 8'h83, "cfg");
    chk("cfg_value", 32'(config_reg), 32'h5383);
    chk("cfg_wr_pulses", 32'(wr_cnt - w0), 32'd1);
    chk("cfg_busy", 32'(busy), 32'd1);
    i2c_start;
    wr_byte(8'h93, 1'b1, "busyrd_addr_ack");
    rd_byte(8'h53, 1'b0, "busyrd_msb");
    rd_byte(8'h83, 1'b1, "busyrd_lsb");
    i2c_stop;
    chk("busy_during_read", 32'(busy), 32'd1);
    wait_busy_low;
    chk("busy_length", 32'(last_len), 32'(CONV));
    i2c_start;
    wr_byte(8'h93, 1'b1, "idlerd_addr_ack");
    rd_byte(8'hD3, 1'b0, "idlerd_msb");
    rd_byte(8'h83, 1'b1, "idlerd_lsb");
    i2c_stop;
    read2(8'h00, 16'h1234, "conv");
    i2c_start;
    wr_byte(8'h92, 1'b1, "wrap_waddr_ack");
    wr_byte(8'h02, 1'b1, "wrap_ptr_ack");
    i2c_start;
    wr_byte(8'h93, 1'b1, "wrap_raddr_ack");
    rd_byte(8'h80, 1'b0, "wrap_b0");
    rd_byte(8'h00, 1'b0, "wrap_b1");
    rd_byte(8'h80, 1'b1, "wrap_b2");
    i2c_stop;
    read2(8'h03, 16'h7FFF, "thr_hi");
    w0 = wr_cnt;
    write_cfg(8'h02, 8'h11, 8'h22, "ptr2_commit");
    chk("ptr2_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("ptr2_config", 32'(config_reg), 32'h5383);
    i2c_start;
    wr_byte(8'h92, 1'b1, "dangle_addr_ack");
    wr_byte(8'h01, 1'b1, "dangle_ptr_ack");
    wr_byte(8'hAB, 1'b1, "dangle_msb_ack");
    i2c_stop;
    chk("dangle_config", 32'(config_reg), 32'h5383);
    w0 = wr_cnt;
    write_cfg(8'h01, 8'h05, 8'h83, "after_dangle");
    chk("after_dangle_config", 32'(config_reg), 32'h0583);
    chk("after_dangle_wr", 32'(wr_cnt - w0), 32'd1);
    write_cfg(8'h01, 8'hC5, 8'h83, "restart_a");
    wait_clk(200);
    write_cfg(8'h01, 8'hE5, 8'h83, "restart_b");
    chk("restart_config", 32'(config_reg), 32'h6583);
    wait_busy_low;
    chk("restart_busy_length", 32'(last_len), 32'(CONV));
    read2(8'h00, 16'hC0DE, "restart_conv");
    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt;
      write_cfg(8'h01, vecs[i].msb, vecs[i].lsb, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_config", i), 32'(config_reg), 32'(vecs[i].cfg));
      chk($sformatf("vec%0d_wr", i), 32'(wr_cnt - w0), 32'd1);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].conv));
      if (busy) wait_busy_low;
      read2(8'h00, vecs[i].result, $sformatf("vec%0d_conv", i));
    end
    i2c_start;
    wr_byte(8'h92, 1'b1, "rst_waddr_ack");
    wr_byte(8'h02, 1'b1, "rst_ptr_ack");
    i2c_start;
    wr_byte(8'h93, 1'b1, "rst_raddr_ack");
    bit_io(1'b1, r);
    chk("rst_first_bit", 32'(r), 32'd1);
    chk("rst_target_drives_zero", 32'(sda), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sda_released", 32'(sda), 32'd1);
    wait_clk(2);
    chk("rst_config", 32'(config_reg), 32'h0583);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    m_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2 * Q);
    i2c_start;
    wr_byte(8'h93, 1'b1, "post_rst_addr_ack");
    rd_byte(8'h00, 1'b0, "post_rst_msb");
    rd_byte(8'h00, 1'b1, "post_rst_lsb");
    i2c_stop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
